conv3x3_mac: RTL and testbench
==============================

CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter SHIFT, default 4, meaning arithmetic right-shift applied to the accumulator before clipping.
REQ-002 SHALL have parameter ACC_W, default 20, meaning the signed accumulator width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port shift_right, input, 1, meaning shift pix_in into the window this cycle.
REQ-006 SHALL have port pix_in, input, 8, meaning the unsigned pixel from the padded image BRAM.
REQ-007 SHALL have port start_conv, input, 1, meaning a level request to convolve the current window.
REQ-008 SHALL have ports k_we, k_addr and k_data: input, 1/4/8; meaning the kernel write strobe, the tap index 0..8 (row-major) and the signed coefficient.
REQ-009 SHALL have port done_conv, output, 1, meaning the result is valid, with four-phase completion.
REQ-010 SHALL have port pix_out, output, 8, meaning the unsigned clipped result.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-012 Window SHALL be 9x8-bit shift register: on shift_right=1, w[0]<=w[1]..w[7]<=w[8], w[8]<=pix_in; after 9 shifts w[0] holds first pixel (top-left).
REQ-013 Shifts SHALL be ignored while busy=1.
REQ-014 Kernel write SHALL occur when k_we=1, busy=0, k_addr<=8; k_addr 9..15 or busy=1 -> write ignored.
REQ-015 FSM states SHALL be IDLE, MAC, NORM, DONE.
REQ-016 IDLE->MAC when start_conv=1; tap counter t<=0, acc<=0.
REQ-017 MAC SHALL add signed({1'b0,w[t]})*k[t] to acc once per cycle for t=0..8, i.e. 9 cycles; MAC->NORM after t=8.
REQ-018 Products SHALL be 17-bit signed and sign-extended to ACC_W; no overflow is possible with ACC_W=20.
REQ-019 NORM SHALL compute r=acc>>>SHIFT, clip to 0..255, register into pix_out, and go to DONE.
REQ-020 DONE SHALL hold done_conv=1 and pix_out stable until start_conv=0, then go to IDLE with done_conv=0 on the next cycle.
REQ-021 Latency SHALL be 11 cycles from the edge sampling start_conv=1 in IDLE to the first cycle with done_conv=1.
REQ-022 start_conv held high across DONE SHALL NOT retrigger; a new job requires start_conv low for at least one cycle in IDLE first.
REQ-023 start_conv dropping during MAC/NORM SHALL NOT abort; the job completes and DONE exits immediately.
REQ-024 pix_out SHALL keep its last value in IDLE until the next NORM.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, t=0, acc=0, window=0, kernel=0, done_conv=0, pix_out=0, busy=0.
REQ-026 Reset mid-MAC SHALL discard the job; no done_conv pulse follows reset release.

Configuration
REQ-027 Macro CONV_ABS_EN defined: NORM SHALL use |acc|>>>SHIFT before clipping (edge magnitude); undefined: negative r clips to 0.

Structure
REQ-028 Package conv_pkg SHALL hold the FSM state encoding, PIX_W=8, COEF_W=8, NTAPS=9 and the clip function.
REQ-029 Window register SHALL be sub-module conv_window_reg (shift enable, hold when busy, reset clear).

Verification
REQ-030 Identity: k[4]=16, others 0, shift in 1..9, start -> done at cycle 11, pix_out=5.
REQ-031 Box saturation: all k=16, nine pixels 255 -> acc=36720, r=2295, pix_out=255.
REQ-032 Laplacian: k[4]=-8, others 1; centre 100, others 0 -> acc=-800, pix_out=0 without CONV_ABS_EN, 50 with it.
REQ-033 Handshake: hold start_conv high 5 cycles after done -> done_conv stays 1, no second job; drop start -> done_conv=0 next cycle; kernel/shift writes during busy ignored.
REQ-034 Reset mid-MAC (cycle 4): done_conv=0, pix_out=0, kernel=0 after release; a new job with reloaded kernel gives correct result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC: data widths, tap count,
// FSM state encoding and the output clipping helper.
package conv_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned COEF_W  = 8;
   localparam int unsigned NTAPS   = 9;
   localparam int unsigned PROD_W  = PIX_W + 1 + COEF_W;  // zero-extended pixel times coefficient
   localparam int unsigned TAP_W   = 4;
   localparam int          PIX_MAX = (1 << PIX_W) - 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMac  = 2'd1,
      StNorm = 2'd2,
      StDone = 2'd3
   } conv_state_e;

   // Saturate a signed value into the unsigned pixel range.
   function automatic logic [PIX_W-1:0] clip_pix(input logic signed [31:0] v);
      logic [PIX_W-1:0] res;
      if (v < 0) begin
         res = '0;
      end else if (v > PIX_MAX) begin
         res = '1;
      end else begin
         res = v[PIX_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_window_reg.sv
// 9-entry pixel window shift register. Entry 0 is the oldest pixel
// (top-left of the window); new pixels enter at entry 8.
import conv_pkg::*;

module conv_window_reg (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        shift_i,
   input  logic                        hold_i,
   input  logic [PIX_W-1:0]            pix_i,
   output logic [NTAPS-1:0][PIX_W-1:0] win_o
);

   logic [NTAPS-1:0][PIX_W-1:0] win_d, win_q;

   // Shift towards entry 0 when enabled and not frozen by a running job.
   always_comb begin
      win_d = win_q;
      if (shift_i && !hold_i) begin
         for (int i = 0; i < NTAPS - 1; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[NTAPS-1] = pix_i;
      end
   end

   // Window state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
      end else begin
         win_q <= win_d;
      end
   end

   assign win_o = win_q;

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution: one tap multiply-accumulate per cycle over a pixel window,
// then arithmetic shift and clip to an 8-bit pixel with a four-phase
// start/done handshake.
// Optional feature: define CONV_ABS_EN to normalise the accumulator magnitude
// (edge-strength output) instead of clipping negative results to zero.
import conv_pkg::*;

module conv3x3_mac #(
   parameter int unsigned SHIFT = 4,
   parameter int unsigned ACC_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_right,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              start_conv,
   input  logic              k_we,
   input  logic [TAP_W-1:0]  k_addr,
   input  logic [COEF_W-1:0] k_data,
   output logic              done_conv,
   output logic [PIX_W-1:0]  pix_out,
   output logic              busy
);

   conv_state_e                  state_d, state_q;
   logic [TAP_W-1:0]             t_d, t_q;
   logic signed [ACC_W-1:0]      acc_d, acc_q;
   logic [PIX_W-1:0]             pix_out_d, pix_out_q;
   logic [NTAPS-1:0][COEF_W-1:0] k_d, k_q;
   logic [NTAPS-1:0][PIX_W-1:0]  win;

   logic signed [PIX_W:0]        pix_s;
   logic signed [COEF_W-1:0]     coef_s;
   logic signed [PROD_W-1:0]     prod;
   logic signed [ACC_W-1:0]      prod_ext;
   logic signed [ACC_W-1:0]      mag;
   logic signed [ACC_W-1:0]      r;
   logic signed [31:0]           r_ext;

   assign busy      = (state_q != StIdle);
   assign done_conv = (state_q == StDone);
   assign pix_out   = pix_out_q;

   conv_window_reg u_window (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_i (shift_right),
      .hold_i  (busy),
      .pix_i   (pix_in),
      .win_o   (win)
   );

   // Kernel tap update; out-of-range addresses and writes during a job are dropped.
   always_comb begin
      k_d = k_q;
      if (k_we && !busy) begin
         for (int i = 0; i < NTAPS; i++) begin
            if (k_addr == TAP_W'(i)) begin
               k_d[i] = k_data;
            end
         end
      end
   end

   // Current tap product and the normalised/clipped result of the accumulator.
   always_comb begin
      pix_s    = $signed({1'b0, win[t_q]});
      coef_s   = $signed(k_q[t_q]);
      prod     = pix_s * coef_s;
      prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`ifdef CONV_ABS_EN
      mag      = acc_q[ACC_W-1] ? -acc_q : acc_q;
`else
      mag      = acc_q;
`endif
      r        = mag >>> SHIFT;
      r_ext    = {{(32-ACC_W){r[ACC_W-1]}}, r};
   end

   // Job sequencing: clear, nine MAC taps, normalise, then hold until start drops.
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      acc_d     = acc_q;
      pix_out_d = pix_out_q;
      unique case (state_q)
         StIdle: begin
            if (start_conv) begin
               state_d = StMac;
               t_d     = '0;
               acc_d   = '0;
            end
         end
         StMac: begin
            acc_d = acc_q + prod_ext;
            if (t_q == TAP_W'(NTAPS - 1)) begin
               state_d = StNorm;
               t_d     = '0;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         StNorm: begin
            pix_out_d = clip_pix(r_ext);
            state_d   = StDone;
         end
         StDone: begin
            if (!start_conv) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control, datapath and kernel registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         t_q       <= '0;
         acc_q     <= '0;
         pix_out_q <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         acc_q     <= acc_d;
         pix_out_q <= pix_out_d;
         k_q       <= k_d;
      end
   end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed, table-driven bench for conv3x3_mac plus hand-written handshake,
// ignored-write and reset-mid-job sequences.
module tb_conv3x3_mac;

   logic       clk;
   logic       rst_n;
   logic       shift_right;
   logic [7:0] pix_in;
   logic       start_conv;
   logic       k_we;
   logic [3:0] k_addr;
   logic [7:0] k_data;
   logic       done_conv;
   logic [7:0] pix_out;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [8:0][7:0] k;
      logic [8:0][7:0] p;
      logic [7:0]      exp;
   } vec_t;

   vec_t vecs [6];

   conv3x3_mac #(.SHIFT(4), .ACC_W(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_right (shift_right),
      .pix_in      (pix_in),
      .start_conv  (start_conv),
      .k_we        (k_we),
      .k_addr      (k_addr),
      .k_data      (k_data),
      .done_conv   (done_conv),
      .pix_out     (pix_out),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_kernel(input logic [8:0][7:0] k);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         k_we = 1'b1; k_addr = 4'(i); k_data = k[i];
      end
      @(negedge clk);
      k_we = 1'b0;
   endtask

   task automatic write_tap(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      k_we = 1'b1; k_addr = a; k_data = d;
      @(negedge clk);
      k_we = 1'b0;
   endtask

   task automatic shift_pixels(input logic [8:0][7:0] p);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         shift_right = 1'b1; pix_in = p[i];
      end
      @(negedge clk);
      shift_right = 1'b0;
   endtask

   // mode 0: hold start 5 cycles into DONE then drop.
   // mode 1: attempt kernel/shift writes while busy and drop start during MAC.
   task automatic run_job(input string name, input int exp, input int mode);
      int first;
      int held;
      first = -1;
      @(negedge clk);
      start_conv = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 30 && first < 0; c++) begin
         @(negedge clk);
         if (mode == 1 && c == 2) begin
            k_we = 1'b1; k_addr = 4'd4; k_data = 8'd0;
            shift_right = 1'b1; pix_in = 8'd200;
         end else begin
            k_we = 1'b0; shift_right = 1'b0;
         end
         if (mode == 1 && c == 3) start_conv = 1'b0;
         if (done_conv) first = c;
      end
      k_we = 1'b0; shift_right = 1'b0;
      check({name, " latency"}, first, 11);
      check({name, " pix_out"}, int'(pix_out), exp);
      if (mode == 0) begin
         held = 0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_conv && busy) held++;
         end
         check({name, " done held"}, held, 5);
         start_conv = 1'b0;
      end
      @(negedge clk);
      check({name, " done after drop"}, int'(done_conv), 0);
      check({name, " busy after drop"}, int'(busy), 0);
      @(negedge clk);
      check({name, " pix_out held in idle"}, int'(pix_out), exp);
   endtask

   initial begin
      logic [8:0][7:0] seq19;
      logic [8:0][7:0] ident;
      int              ndone;

      for (int i = 0; i < 9; i++) seq19[i] = 8'(i + 1);
      ident    = '0;
      ident[4] = 8'd16;

      // identity
      vecs[0].k = ident;  vecs[0].p = seq19; vecs[0].exp = 8'd5;
      // box saturation: 36720 >>> 4 = 2295 -> 255
      for (int i = 0; i < 9; i++) begin vecs[1].k[i] = 8'd16; vecs[1].p[i] = 8'd255; end
      vecs[1].exp = 8'd255;
      // laplacian: acc = -800
      for (int i = 0; i < 9; i++) begin vecs[2].k[i] = 8'd1; vecs[2].p[i] = 8'd0; end
      vecs[2].k[4] = 8'hF8; vecs[2].p[4] = 8'd100;
`ifdef CONV_ABS_EN
      vecs[2].exp = 8'd50;
`else
      vecs[2].exp = 8'd0;
`endif
      // all ones, flat 16: 144 >>> 4 = 9
      for (int i = 0; i < 9; i++) begin vecs[3].k[i] = 8'd1; vecs[3].p[i] = 8'd16; end
      vecs[3].exp = 8'd9;
      // k0 = -128, p0 = 255: acc = -32640
      vecs[4].k = '0; vecs[4].p = '0; vecs[4].k[0] = 8'h80; vecs[4].p[0] = 8'd255;
`ifdef CONV_ABS_EN
      vecs[4].exp = 8'd255;
`else
      vecs[4].exp = 8'd0;
`endif
      // sobel-x on 10..90: -10+30-80+120-70+90 = 80 -> 5
      vecs[5].k = {8'd1, 8'd0, 8'hFF, 8'd2, 8'd0, 8'hFE, 8'd1, 8'd0, 8'hFF};
      for (int i = 0; i < 9; i++) vecs[5].p[i] = 8'(10 * (i + 1));
      vecs[5].exp = 8'd5;

      rst_n = 1'b0; shift_right = 1'b0; pix_in = '0; start_conv = 1'b0;
      k_we = 1'b0; k_addr = '0; k_data = '0;
      #3;
      check("reset done_conv", int'(done_conv), 0);
      check("reset busy", int'(busy), 0);
      check("reset pix_out", int'(pix_out), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         load_kernel(vecs[v].k);
         shift_pixels(vecs[v].p);
         run_job($sformatf("vec%0d", v), int'(vecs[v].exp), 0);
      end

      // Out-of-range kernel addresses must not alias onto real taps.
      load_kernel(ident);
      shift_pixels(seq19);
      write_tap(4'd9, 8'd100);
      write_tap(4'd12, 8'd0);
      write_tap(4'd15, 8'd50);
      run_job("addr_range", 5, 0);

      // Writes during busy ignored; start dropped mid-MAC still completes.
      run_job("busy_writes", 5, 1);
      run_job("busy_rerun", 5, 0);

      // Reset during MAC at cycle 4.
      @(negedge clk);
      start_conv = 1'b1;
      @(posedge clk);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset busy", int'(busy), 0);
      check("midreset done_conv", int'(done_conv), 0);
      check("midreset pix_out", int'(pix_out), 0);
      start_conv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done_conv || busy) ndone++;
      end
      check("post reset no done", ndone, 0);
      shift_pixels(seq19);
      run_job("kernel cleared", 0, 0);
      load_kernel(ident);
      run_job("reload identity", 5, 0);

      // Window cleared by reset.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      load_kernel(ident);
      run_job("window cleared", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
